bus_hub_n: RTL and testbench
============================

BUS_HUB_N -- requirements
Module: bus_hub_n

Interface
REQ-001 SHALL have parameter N_DEVICES, default 2: number of device ports (1..16).
REQ-002 SHALL have parameter DEV_BASE, default {32'h0001_0000, 32'h0000_0000}: packed N_DEVICES*32 base addresses; device i is at [32*i +: 32].
REQ-003 SHALL have parameter DEV_MASK, default {32'hFFFF_0000, 32'hFFFF_0000}: packed N_DEVICES*32 decode masks.
REQ-004 SHALL have parameter TIMEOUT, default 255: maximum number of BUSY cycles before abort (>=1).
REQ-005 SHALL have parameter ERR_DATA, default 32'hDEAD_BEEF: read data returned on error.
REQ-006 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have ports host_address, host_data_write, host_write_mask, host_wen and host_ren as inputs, widths 32/32/4/1/1: host request.
REQ-009 SHALL have ports host_data_read (output, 32), host_ready (output, 1) and host_error (output, 1): host response.
REQ-010 SHALL have ports device_address and device_data_write as outputs, width N_DEVICES*32: per-device offset address and write data.
REQ-011 SHALL have ports device_write_mask (output, N_DEVICES*4), device_wen (output, N_DEVICES) and device_ren (output, N_DEVICES): per-device write mask and strobes.
REQ-012 SHALL have ports device_ready (input, N_DEVICES) and device_data_read (input, N_DEVICES*32): per-device completion and read data.

Function
REQ-013 SHALL implement states IDLE, BUSY, RESP.
REQ-014 IDLE: when host_wen or host_ren is 1 at a rising edge, the hub SHALL latch address, write data, mask and op (write if host_wen=1, else read).
REQ-015 On acceptance, the hub SHALL select the lowest index i with (host_address & MASK_i) == BASE_i.
REQ-016 On a decode hit, the hub SHALL enter BUSY; on a miss, it SHALL enter RESP with error flag set and read data ERR_DATA.
REQ-017 BUSY: only the selected device's wen or ren SHALL be 1, held high until completion or abort; all other strobes SHALL be 0.
REQ-018 In every state, all device ports SHALL carry the latched write data and mask, and an address equal to the latched address & ~MASK_i.
REQ-019 BUSY: when device_ready[sel] is 1 at an edge, the hub SHALL register device_data_read[sel] (reads; 0 for writes) into host_data_read and enter RESP with error=0.
REQ-020 BUSY: a cycle counter SHALL reset to 0 on entry and increment each cycle; at count TIMEOUT-1 without ready, the hub SHALL abort to RESP with error=1 and data ERR_DATA.
REQ-021 If ready and timeout occur in the same cycle, ready SHALL win.
REQ-022 RESP SHALL last exactly one cycle with host_ready=1, host_error per flag and host_data_read valid, then return to IDLE.
REQ-023 host_ready and host_error SHALL be 0 outside RESP; host_data_read SHALL hold its last value outside RESP.
REQ-024 Latency: for a device ready in the first strobe cycle, request sampled at edge E gives strobes in cycle E+1 and host_ready in cycle E+2; for a decode miss, host_ready is in cycle E+1.
REQ-025 device_ready from any device SHALL be ignored outside BUSY and, in BUSY, from any non-selected device, including late ready after an abort.
REQ-026 A host strobe still asserted in the IDLE cycle following RESP SHALL start a new transaction.
REQ-027 Requests SHALL be latched, so host inputs may change after acceptance.

Reset
REQ-028 While rst=1: state IDLE; counter 0; all device_wen/device_ren 0; host_ready 0; host_error 0; host_data_read 0; latched address/data/mask 0.
REQ-029 Reset asserted mid-transaction SHALL drop all strobes immediately (asynchronously) with no host_ready pulse.
REQ-030 First acceptance SHALL be possible at the first rising edge after rst deasserts.

Verification
REQ-031 Read 0x0000_0010 with device0 ready in the first strobe cycle, data 0x1234_5678 -> device0 ren with address 0x10 in cycle E+1; host_ready=1, error=0, data 0x1234_5678 in cycle E+2.
REQ-032 Write 0x0001_0004, mask 4'b0011, data 0xAABB_CCDD, device1 ready after 3 wait cycles -> device1 wen high 4 cycles with address 0x4 and mask 0011; device0 strobes stay 0; one host_ready pulse.
REQ-033 Read 0x0002_0000 (unmapped) -> host_ready and host_error =1 in cycle E+1, data 0xDEAD_BEEF; no device strobe.
REQ-034 TIMEOUT=4, device never ready -> strobe high exactly 4 cycles, then host_error=1 with 0xDEAD_BEEF; a later ready from that device is ignored.
REQ-035 Overlapping DEV_BASE/DEV_MASK plus ready and timeout in the same cycle -> lowest index selected; ready wins with error=0.
REQ-036 rst pulsed during BUSY -> strobes drop asynchronously, no host_ready; a new read after reset completes normally.

Source files
------------

// File: rtl/bus_hub_n.sv
// bus_hub_n: single-host hub that decodes requests onto N device ports, with busy timeout and error response
module bus_hub_n #(
    parameter int                      N_DEVICES = 2,
    parameter logic [N_DEVICES*32-1:0] DEV_BASE  = {32'h0001_0000, 32'h0000_0000},
    parameter logic [N_DEVICES*32-1:0] DEV_MASK  = {32'hFFFF_0000, 32'hFFFF_0000},
    parameter int                      TIMEOUT   = 255,
    parameter logic [31:0]             ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               host_address,
    input  logic [31:0]               host_data_write,
    input  logic [3:0]                host_write_mask,
    input  logic                      host_wen,
    input  logic                      host_ren,
    output logic [31:0]               host_data_read,
    output logic                      host_ready,
    output logic                      host_error,
    output logic [N_DEVICES*32-1:0]   device_address,
    output logic [N_DEVICES*32-1:0]   device_data_write,
    output logic [N_DEVICES*4-1:0]    device_write_mask,
    output logic [N_DEVICES-1:0]      device_wen,
    output logic [N_DEVICES-1:0]      device_ren,
    input  logic [N_DEVICES-1:0]      device_ready,
    input  logic [N_DEVICES*32-1:0]   device_data_read
);
    localparam int SW = (N_DEVICES > 1) ? $clog2(N_DEVICES) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    r_state;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_mask;
    logic          r_write;
    logic [SW-1:0] r_sel;
    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic [31:0]   r_rdata;
    logic          w_hit;
    logic [SW-1:0] w_idx;
    logic          w_ready;
    logic [31:0]   w_rdata;

    // Address decode (descending scan so the lowest matching index wins) and selected-device response mux
    always_comb begin
        w_hit   = 1'b0;
        w_idx   = '0;
        w_ready = 1'b0;
        w_rdata = '0;
        for (int i = N_DEVICES - 1; i >= 0; i--) begin
            if ((host_address & DEV_MASK[32*i +: 32]) == DEV_BASE[32*i +: 32]) begin
                w_hit = 1'b1;
                w_idx = SW'(i);
            end
            if (r_sel == SW'(i)) begin
                w_ready = device_ready[i];
                w_rdata = device_data_read[32*i +: 32];
            end
        end
    end

    // Transaction FSM: accept and latch, wait on device or timeout, one-cycle response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_mask  <= '0;
            r_write <= 1'b0;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (host_wen || host_ren) begin
                    r_addr  <= host_address;
                    r_wdata <= host_data_write;
                    r_mask  <= host_write_mask;
                    r_write <= host_wen;
                    r_sel   <= w_idx;
                    r_cnt   <= '0;
                    r_state <= w_hit ? S_BUSY : S_RESP;
                    if (!w_hit) begin
                        r_err   <= 1'b1;
                        r_rdata <= ERR_DATA;
                    end
                end
                S_BUSY: if (w_ready) begin
                    r_rdata <= r_write ? 32'h0 : w_rdata;
                    r_err   <= 1'b0;
                    r_state <= S_RESP;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    r_rdata <= ERR_DATA;
                    r_err   <= 1'b1;
                    r_state <= S_RESP;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                S_RESP: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < N_DEVICES; g++) begin : g_dev
        assign device_address[32*g +: 32]  = r_addr & ~DEV_MASK[32*g +: 32];
        assign device_data_write[32*g +: 32] = r_wdata;
        assign device_write_mask[4*g +: 4]   = r_mask;
        assign device_wen[g] = (r_state == S_BUSY) && (r_sel == SW'(g)) && r_write;
        assign device_ren[g] = (r_state == S_BUSY) && (r_sel == SW'(g)) && !r_write;
    end

    assign host_ready     = (r_state == S_RESP);
    assign host_error     = host_ready && r_err;
    assign host_data_read = r_rdata;
endmodule

// File: tb/tb_bus_hub_n.sv
// tb_bus_hub_n: scoreboard bench for bus_hub_n with a programmable-latency device model
module tb_bus_hub_n;
    localparam int N  = 3;
    localparam int TO = 4;
    localparam logic [N*32-1:0] BASE = {32'h0000_0000, 32'h0001_0000, 32'h0000_0000};
    localparam logic [N*32-1:0] MASK = {32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_0000};

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [31:0]     host_address = '0;
    logic [31:0]     host_data_write = '0;
    logic [3:0]      host_write_mask = '0;
    logic            host_wen = 1'b0;
    logic            host_ren = 1'b0;
    logic [31:0]     host_data_read;
    logic            host_ready;
    logic            host_error;
    logic [N*32-1:0] device_address;
    logic [N*32-1:0] device_data_write;
    logic [N*4-1:0]  device_write_mask;
    logic [N-1:0]    device_wen;
    logic [N-1:0]    device_ren;
    logic [N-1:0]    device_ready;
    logic [N*32-1:0] device_data_read;

    typedef struct {logic [31:0] d; logic e;} resp_t;
    resp_t q[$];
    resp_t r;
    int n_cmp = 0;
    int n_bad = 0;

    int          lat[N];
    int          scnt[N];
    logic [31:0] rd[N];
    logic [N-1:0] force_rdy = '0;

    bus_hub_n #(.N_DEVICES(N), .DEV_BASE(BASE), .DEV_MASK(MASK), .TIMEOUT(TO), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .rst(rst),
        .host_address(host_address), .host_data_write(host_data_write), .host_write_mask(host_write_mask),
        .host_wen(host_wen), .host_ren(host_ren),
        .host_data_read(host_data_read), .host_ready(host_ready), .host_error(host_error),
        .device_address(device_address), .device_data_write(device_data_write), .device_write_mask(device_write_mask),
        .device_wen(device_wen), .device_ren(device_ren),
        .device_ready(device_ready), .device_data_read(device_data_read)
    );

    always #5 clk = ~clk;

    // Device model: ready after lat[i] completed strobe cycles, or forced
    always @(posedge clk)
        for (int i = 0; i < N; i++) scnt[i] <= (device_wen[i] | device_ren[i]) ? scnt[i] + 1 : 0;

    always_comb begin
        device_ready = '0;
        device_data_read = '0;
        for (int i = 0; i < N; i++) begin
            device_ready[i] = force_rdy[i] | ((device_wen[i] | device_ren[i]) && (scnt[i] == lat[i]));
            device_data_read[32*i +: 32] = rd[i];
        end
    end

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_cmp++; if (host_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got %b want 0", host_ready); end
        n_cmp++; if (host_error !== 1'b0) begin n_bad++; $display("FAIL rst_error got %b want 0", host_error); end
        n_cmp++; if (host_data_read !== 32'h0) begin n_bad++; $display("FAIL rst_data got %h want 0", host_data_read); end
        n_cmp++; if ((device_wen | device_ren) !== '0) begin n_bad++; $display("FAIL rst_strobes got %b/%b want 0", device_wen, device_ren); end
        n_cmp++; if (device_address !== '0 || device_data_write !== '0 || device_write_mask !== '0) begin
            n_bad++; $display("FAIL rst_latched got %h %h %h want 0", device_address, device_data_write, device_write_mask); end
        rst = 1'b0;
    endtask

    task automatic test_read;
        rd[0] = 32'h1234_5678; lat[0] = 0;
        host_address = 32'h0000_0010; host_ren = 1'b1;
        q.push_back('{32'h1234_5678, 1'b0});
        @(negedge clk);
        n_cmp++; if (device_ren !== 3'b001 || device_wen !== 3'b000) begin n_bad++; $display("FAIL read_strobe got ren %b wen %b want 001/000", device_ren, device_wen); end
        n_cmp++; if (device_address[31:0] !== 32'h10) begin n_bad++; $display("FAIL read_addr got %h want 00000010", device_address[31:0]); end
        n_cmp++; if (host_ready !== 1'b0) begin n_bad++; $display("FAIL read_early_ready got %b want 0", host_ready); end
        host_ren = 1'b0; host_address = 32'hFFFF_FFFF; host_data_write = 32'h5555_5555;
        @(negedge clk);
        n_cmp++; if (host_ready !== 1'b1) begin n_bad++; $display("FAIL read_ready got %b want 1", host_ready); end
        if (host_ready && q.size() > 0) begin
            r = q.pop_front();
            n_cmp++; if (host_data_read !== r.d || host_error !== r.e) begin n_bad++; $display("FAIL read_resp got %h/%b want %h/%b", host_data_read, host_error, r.d, r.e); end
        end
        n_cmp++; if (device_address[31:0] !== 32'h10) begin n_bad++; $display("FAIL read_latch got %h want 00000010", device_address[31:0]); end
        @(negedge clk);
        n_cmp++; if (host_ready !== 1'b0 || host_data_read !== 32'h1234_5678) begin n_bad++; $display("FAIL read_hold got %b/%h want 0/12345678", host_ready, host_data_read); end
    endtask

    task automatic test_write;
        int wen_c = 0, other = 0, pulses = 0;
        rd[1] = 32'h9999_9999; lat[1] = 3;
        host_address = 32'h0001_0004; host_write_mask = 4'b0011; host_data_write = 32'hAABB_CCDD; host_wen = 1'b1;
        q.push_back('{32'h0, 1'b0});
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            host_wen = 1'b0;
            if (device_wen[1]) wen_c++;
            if (device_ren != 0 || device_wen[0] || device_wen[2]) other++;
            if (c == 0) begin
                n_cmp++; if (device_address[63:32] !== 32'h4 || device_write_mask[7:4] !== 4'b0011 || device_data_write[63:32] !== 32'hAABB_CCDD) begin
                    n_bad++; $display("FAIL write_port got %h/%b/%h want 00000004/0011/aabbccdd", device_address[63:32], device_write_mask[7:4], device_data_write[63:32]); end
                n_cmp++; if (device_write_mask[3:0] !== 4'b0011 || device_data_write[31:0] !== 32'hAABB_CCDD) begin
                    n_bad++; $display("FAIL write_bcast got %b/%h want 0011/aabbccdd", device_write_mask[3:0], device_data_write[31:0]); end
            end
            if (host_ready) begin
                pulses++;
                if (q.size() > 0) begin
                    r = q.pop_front();
                    n_cmp++; if (host_data_read !== r.d || host_error !== r.e) begin n_bad++; $display("FAIL write_resp got %h/%b want %h/%b", host_data_read, host_error, r.d, r.e); end
                end
            end
        end
        n_cmp++; if (wen_c !== 4) begin n_bad++; $display("FAIL write_wen_cycles got %0d want 4", wen_c); end
        n_cmp++; if (other !== 0) begin n_bad++; $display("FAIL write_other_strobes got %0d want 0", other); end
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL write_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_miss;
        host_address = 32'h0002_0000; host_ren = 1'b1;
        q.push_back('{32'hDEAD_BEEF, 1'b1});
        @(negedge clk);
        host_ren = 1'b0;
        n_cmp++; if (host_ready !== 1'b1) begin n_bad++; $display("FAIL miss_ready got %b want 1", host_ready); end
        if (host_ready && q.size() > 0) begin
            r = q.pop_front();
            n_cmp++; if (host_data_read !== r.d || host_error !== r.e) begin n_bad++; $display("FAIL miss_resp got %h/%b want %h/%b", host_data_read, host_error, r.d, r.e); end
        end
        n_cmp++; if ((device_wen | device_ren) !== '0) begin n_bad++; $display("FAIL miss_strobes got %b want 0", device_wen | device_ren); end
        @(negedge clk);
        n_cmp++; if (host_ready !== 1'b0 || host_error !== 1'b0) begin n_bad++; $display("FAIL miss_after got %b/%b want 0/0", host_ready, host_error); end
    endtask

    task automatic test_timeout;
        int ren_c = 0, pulses = 0, late = 0;
        lat[0] = 99; host_address = 32'h0000_0020; host_ren = 1'b1;
        q.push_back('{32'hDEAD_BEEF, 1'b1});
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            host_ren = 1'b0;
            if (device_ren[0]) ren_c++;
            if (late > 0 && (device_wen | device_ren) != 0) late++;
            if (host_ready) begin
                pulses++;
                force_rdy[0] = 1'b1;
                if (late == 0) late = 1;
                if (q.size() > 0) begin
                    r = q.pop_front();
                    n_cmp++; if (host_data_read !== r.d || host_error !== r.e) begin n_bad++; $display("FAIL to_resp got %h/%b want %h/%b", host_data_read, host_error, r.d, r.e); end
                end
            end
        end
        force_rdy[0] = 1'b0;
        n_cmp++; if (ren_c !== TO) begin n_bad++; $display("FAIL to_strobe_cycles got %0d want %0d", ren_c, TO); end
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL to_pulses got %0d want 1", pulses); end
        n_cmp++; if (late !== 1) begin n_bad++; $display("FAIL to_late_ready got %0d want 1", late); end
        n_cmp++; if (host_data_read !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL to_hold got %h want deadbeef", host_data_read); end
    endtask

    task automatic test_overlap;
        int ren0 = 0, ren2 = 0, pulses = 0;
        lat[0] = 3; rd[0] = 32'hCAFE_0001; rd[2] = 32'hBAD0_0002; force_rdy[2] = 1'b1;
        host_address = 32'h0000_0040; host_ren = 1'b1;
        q.push_back('{32'hCAFE_0001, 1'b0});
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            host_ren = 1'b0;
            if (device_ren[0]) ren0++;
            if (device_ren[2]) ren2++;
            if (c == 0) begin
                n_cmp++; if (device_address[95:64] !== 32'h40) begin n_bad++; $display("FAIL ovl_addr2 got %h want 00000040", device_address[95:64]); end
            end
            if (host_ready) begin
                pulses++;
                if (q.size() > 0) begin
                    r = q.pop_front();
                    n_cmp++; if (host_data_read !== r.d || host_error !== r.e) begin n_bad++; $display("FAIL ovl_resp got %h/%b want %h/%b", host_data_read, host_error, r.d, r.e); end
                end
            end
        end
        force_rdy[2] = 1'b0;
        n_cmp++; if (ren0 !== 4 || ren2 !== 0) begin n_bad++; $display("FAIL ovl_select got ren0 %0d ren2 %0d want 4/0", ren0, ren2); end
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL ovl_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_back_to_back;
        int pulses = 0, first = -1, second = -1;
        lat[0] = 0; rd[0] = 32'h1111_0000;
        host_address = 32'h0000_0010; host_ren = 1'b1;
        q.push_back('{32'h1111_0000, 1'b0});
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (host_ready) begin
                pulses++;
                if (q.size() > 0) begin
                    r = q.pop_front();
                    n_cmp++; if (host_data_read !== r.d || host_error !== r.e) begin n_bad++; $display("FAIL b2b_resp got %h/%b want %h/%b", host_data_read, host_error, r.d, r.e); end
                end
                if (pulses == 1) begin first = c; rd[0] = 32'h2222_0000; q.push_back('{32'h2222_0000, 1'b0}); end
                if (pulses == 2) begin second = c; host_ren = 1'b0; end
            end
        end
        n_cmp++; if (pulses !== 2) begin n_bad++; $display("FAIL b2b_pulses got %0d want 2", pulses); end
        n_cmp++; if (second - first !== 3) begin n_bad++; $display("FAIL b2b_spacing got %0d want 3", second - first); end
    endtask

    task automatic test_reset_mid;
        int pulses = 0;
        lat[0] = 99; host_address = 32'h0000_0010; host_ren = 1'b1;
        @(negedge clk);
        host_ren = 1'b0;
        n_cmp++; if (device_ren[0] !== 1'b1) begin n_bad++; $display("FAIL rmid_busy got %b want 1", device_ren[0]); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ((device_wen | device_ren) !== '0) begin n_bad++; $display("FAIL rmid_async_drop got %b want 0", device_wen | device_ren); end
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (host_data_read !== 32'h0) begin n_bad++; $display("FAIL rmid_data got %h want 0", host_data_read); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (host_ready) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL rmid_no_ready got %0d want 0", pulses); end
        lat[0] = 0; rd[0] = 32'h7777_1234; host_ren = 1'b1;
        q.push_back('{32'h7777_1234, 1'b0});
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            host_ren = 1'b0;
            if (host_ready) begin
                pulses++;
                if (q.size() > 0) begin
                    r = q.pop_front();
                    n_cmp++; if (host_data_read !== r.d || host_error !== r.e) begin n_bad++; $display("FAIL rmid_resp got %h/%b want %h/%b", host_data_read, host_error, r.d, r.e); end
                end
            end
        end
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL rmid_pulses got %0d want 1", pulses); end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin lat[i] = 99; rd[i] = '0; end
        test_reset;
        test_read;
        test_write;
        test_miss;
        test_timeout;
        test_overlap;
        test_back_to_back;
        test_reset_mid;
        n_cmp++; if (q.size() !== 0) begin n_bad++; $display("FAIL scoreboard_left got %0d want 0", q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
